// File: rtl/id_stage.sv
// RV32I decode stage: register file, immediate/control decode, load-use stall.
// Optional define ID_WB_BYPASS_EN: same-cycle WB->ID write-through on reads.
module id_stage #(
  parameter int          XLEN     = 32,
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            ex_stall,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_pc,
  input  logic [31:0]     if_id_instr,
  input  logic            if_id_pred_taken,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_stall,
  output logic            id_ex_valid,
  output logic [31:0]     id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic [3:0]      id_ex_alu_op,
  output logic            id_ex_alu_src,
  output logic            id_ex_mem_read,
  output logic            id_ex_mem_write,
  output logic            id_ex_reg_write,
  output logic            id_ex_branch,
  output logic            id_ex_jump,
  output logic            id_ex_pred_taken,
  output logic            id_ex_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] rf [NUM_REGS];

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic        f7b5;

  assign ins  = if_id_instr;
  assign opc  = ins[6:0];
  assign rd   = ins[11:7];
  assign f3   = ins[14:12];
  assign rs1  = ins[19:15];
  assign rs2  = ins[24:20];
  assign f7b5 = ins[30];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  // control bundle: {alu_op, alu_src, mem_read, mem_write,
  //                  reg_write, branch, jump, illegal}
  logic [10:0] dec_ctl, ctl_q;
  logic [3:0]  d_aop;
  logic        d_src, d_mr, d_mw, d_rw, d_br, d_jp, d_ill;
  logic        use1, use2;
  logic [31:0] d_imm;

  // Decode opcode into control, immediate and operand usage.
  always_comb begin
    d_aop = 4'b0000;
    d_src = 1'b0;
    d_mr  = 1'b0;
    d_mw  = 1'b0;
    d_rw  = 1'b0;
    d_br  = 1'b0;
    d_jp  = 1'b0;
    d_ill = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    d_imm = 32'h0;
    unique case (1'b1)
      opc == OP_LUI,
      opc == OP_AUIPC: begin
        d_imm = imm_u;
        d_src = 1'b1;
        d_rw  = 1'b1;
      end
      opc == OP_JAL: begin
        d_imm = imm_j;
        d_src = 1'b1;
        d_rw  = 1'b1;
        d_jp  = 1'b1;
      end
      opc == OP_JALR: begin
        d_imm = imm_i;
        d_src = 1'b1;
        d_rw  = 1'b1;
        d_jp  = 1'b1;
        use1  = 1'b1;
      end
      opc == OP_BRANCH: begin
        d_imm = imm_b;
        d_br  = 1'b1;
        use1  = 1'b1;
        use2  = 1'b1;
      end
      opc == OP_LOAD: begin
        d_imm = imm_i;
        d_src = 1'b1;
        d_mr  = 1'b1;
        d_rw  = 1'b1;
        use1  = 1'b1;
      end
      opc == OP_STORE: begin
        d_imm = imm_s;
        d_src = 1'b1;
        d_mw  = 1'b1;
        use1  = 1'b1;
        use2  = 1'b1;
      end
      opc == OP_IMM: begin
        d_imm = imm_i;
        d_src = 1'b1;
        d_rw  = 1'b1;
        use1  = 1'b1;
        d_aop = (f3 == 3'b101) ? {f7b5, f3} : {1'b0, f3};
      end
      opc == OP_REG: begin
        d_rw  = 1'b1;
        use1  = 1'b1;
        use2  = 1'b1;
        d_aop = {f7b5, f3};
      end
      opc == OP_FENCE,
      opc == OP_SYSTEM: begin
        d_imm = imm_i;
      end
      default: d_ill = 1'b1;
    endcase
  end

  assign dec_ctl = {d_aop, d_src, d_mr, d_mw,
                    d_rw & (rd != 5'd0), d_br, d_jp, d_ill};

  logic [XLEN-1:0] rd1, rd2;

`ifdef ID_WB_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = wb_we & (wb_rd != 5'd0) & (wb_rd == rs1);
  assign byp2 = wb_we & (wb_rd != 5'd0) & (wb_rd == rs2);
  assign rd1  = (rs1 == 5'd0) ? '0 : byp1 ? wb_data : rf[rs1];
  assign rd2  = (rs2 == 5'd0) ? '0 : byp2 ? wb_data : rf[rs2];
`else
  assign rd1  = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rd2  = (rs2 == 5'd0) ? '0 : rf[rs2];
`endif

  logic luh;

  assign luh = id_ex_valid & id_ex_mem_read & (id_ex_rd != 5'd0)
             & if_id_valid
             & ((use1 & (id_ex_rd == rs1)) | (use2 & (id_ex_rd == rs2)));

  assign id_stall = (luh | ex_stall) & ~flush;

  // Register file write port; x0 is never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  logic take;
  assign take = if_id_valid & ~luh;

  // ID/EX register: flush clears, ex_stall holds, else latch/bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_ex_valid      <= 1'b0;
      id_ex_pc         <= RESET_PC;
      id_ex_rs1_data   <= '0;
      id_ex_rs2_data   <= '0;
      id_ex_imm        <= '0;
      id_ex_rs1        <= 5'd0;
      id_ex_rs2        <= 5'd0;
      id_ex_rd         <= 5'd0;
      id_ex_pred_taken <= 1'b0;
      ctl_q            <= '0;
    end else if (flush) begin
      id_ex_valid      <= 1'b0;
      id_ex_pc         <= RESET_PC;
      id_ex_rs1_data   <= '0;
      id_ex_rs2_data   <= '0;
      id_ex_imm        <= '0;
      id_ex_rs1        <= 5'd0;
      id_ex_rs2        <= 5'd0;
      id_ex_rd         <= 5'd0;
      id_ex_pred_taken <= 1'b0;
      ctl_q            <= '0;
    end else if (!ex_stall) begin
      id_ex_valid      <= take;
      id_ex_pc         <= if_id_pc;
      id_ex_rs1_data   <= rd1;
      id_ex_rs2_data   <= rd2;
      id_ex_imm        <= d_imm;
      id_ex_rs1        <= rs1;
      id_ex_rs2        <= rs2;
      id_ex_rd         <= rd;
      id_ex_pred_taken <= if_id_pred_taken;
      ctl_q            <= take ? dec_ctl : '0;
    end
  end

  assign id_ex_alu_op    = ctl_q[10:7];
  assign id_ex_alu_src   = ctl_q[6];
  assign id_ex_mem_read  = ctl_q[5];
  assign id_ex_mem_write = ctl_q[4];
  assign id_ex_reg_write = ctl_q[3];
  assign id_ex_branch    = ctl_q[2];
  assign id_ex_jump      = ctl_q[1];
  assign id_ex_illegal   = ctl_q[0];

endmodule
